// File: rtl/ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl
//
// Pipeline controller for the EX stage of a classic five-stage pipeline. It
// sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their
// enable, bubble and flush controls. It provides four functions:
//   * load-use hazard detection: stalls IF/ID for one cycle and bubbles ID/EX
//     while a load in EX feeds an instruction waiting in ID.
//   * operand forwarding selects for the two EX ALU operands.
//   * multi-cycle MDU (mul/div) sequencing: holds EX and bubbles EX/MEM
//     until the MDU result is ready.
//   * wrong-path flush when MEM resolves a taken branch.
//
// Parameters
//   MDU_LATENCY   cycles an MDU op occupies EX (must be >= 2)
//   STALL_CNT_W   width of the saturating stall-cycle counter
//
// Ports
//   clk               clock, all state updates on the rising edge
//   reset             synchronous, active-high
//   id_valid          ID holds a real instruction
//   id_rs, id_rt      ID source registers
//   id_uses_rt        ID instruction reads rt
//   ex_valid          EX holds a real instruction
//   ex_rs, ex_rt      EX source registers
//   ex_mem_read       EX instruction is a load
//   ex_rd             EX destination register
//   ex_mdu_start      EX instruction is an MDU op (held while it sits in EX)
//   mem_reg_write     MEM instruction writes a register
//   mem_rd            MEM destination register
//   mem_branch_taken  MEM resolved a taken branch
//   wb_reg_write      WB instruction writes a register
//   wb_rd             WB destination register
//   pc_write          PC enable
//   if_id_write       IF/ID enable
//   id_ex_write       ID/EX enable (0 holds the instruction in EX)
//   id_ex_bubble      load a NOP into ID/EX
//   ex_mem_bubble     load a NOP into EX/MEM
//   flush_if_id       clear IF/ID
//   flush_id_ex       clear ID/EX
//   mdu_busy          high while the MDU sequencer is in its busy state
//   fwd_a, fwd_b      ALU operand select: 00 register file, 10 EX/MEM,
//                     01 MEM/WB
//   stall_count       number of cycles with pc_write low, saturating
// ----------------------------------------------------------------------------
module ex_hazard_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   id_valid,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,

    input  logic                   ex_valid,
    input  logic [4:0]             ex_rs,
    input  logic [4:0]             ex_rt,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_mdu_start,

    input  logic                   mem_reg_write,
    input  logic [4:0]             mem_rd,
    input  logic                   mem_branch_taken,

    input  logic                   wb_reg_write,
    input  logic [4:0]             wb_rd,

    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_ex_write,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_bubble,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic                   mdu_busy,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // ------------------------------------------------------------------------
    // Local constants and types
    // ------------------------------------------------------------------------
    localparam int CNT_W = $clog2(MDU_LATENCY);

    // The start cycle is the first EX cycle and the release cycle is the
    // last, so the busy state sees MDU_LATENCY-2 stall cycles before release.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 2);

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // ------------------------------------------------------------------------
    // Hazard conditions
    // ------------------------------------------------------------------------
    logic branch_flush;
    logic mdu_enter;
    logic mdu_hold;
    logic load_use;
    logic rs_dep;
    logic rt_dep;

    assign branch_flush = mem_branch_taken;

    // A new MDU op is accepted only from RUN; while busy, ex_mdu_start is
    // simply the same op still sitting in EX.
    assign mdu_enter = (state == RUN) && ex_valid && ex_mdu_start;
    assign mdu_hold  = (state == MDU_BUSY) && (cnt != '0);

    assign rs_dep   = (ex_rd == id_rs);
    assign rt_dep   = id_uses_rt && (ex_rd == id_rt);

    // r0 is hardwired to zero, so a load targeting it never creates a hazard.
    // Load-use only takes effect when neither branch nor MDU claims the
    // cycle, which restricts it to RUN and the MDU release cycle.
    assign load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0)
                      && (rs_dep || rt_dep);

    // ------------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------------
    // The EX/MEM result is younger than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == src)) begin
            return FWD_EXMEM;
        end
        if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == src)) begin
            return FWD_MEMWB;
        end
        return FWD_REG;
    endfunction

    // ------------------------------------------------------------------------
    // Pipeline control (combinational, priority branch > MDU > load-use)
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        mdu_busy      = 1'b0;
        fwd_a         = FWD_REG;
        fwd_b         = FWD_REG;

        if (!reset) begin
            mdu_busy = (state == MDU_BUSY);
            fwd_a    = fwd_sel(ex_rs);
            fwd_b    = fwd_sel(ex_rt);

            if (branch_flush) begin
                // Kill the two wrong-path instructions behind the branch and
                // squash whatever EX would hand to MEM; fetch continues from
                // the branch target.
                flush_if_id   = 1'b1;
                flush_id_ex   = 1'b1;
                ex_mem_bubble = 1'b1;
            end else if (mdu_enter || mdu_hold) begin
                // Freeze everything up to and including EX; MEM sees NOPs
                // until the MDU result is ready.
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_bubble = 1'b1;
            end else if (load_use) begin
                // Hold the consumer in ID for one cycle while the load moves
                // on to MEM, and send a NOP into EX behind it.
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // MDU sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else if (branch_flush) begin
            // A taken branch kills the MDU op in EX, including one that is
            // just arriving this cycle.
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mdu_enter) begin
                        state <= MDU_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                MDU_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Release cycle: EX/MEM captures the result now.
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Stall-cycle counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_hazard_ctrl
//
// Drives two instances of ex_hazard_ctrl with identical stimulus: one with a
// 16-bit stall counter and one with a 2-bit counter to exercise saturation.
// A behavioural model tracks how many cycles the current MDU op has spent in
// EX and how many stall cycles have elapsed, and a compare process checks
// both instances against it on every falling edge. Directed scenarios add
// hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_ex_hazard_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_rt, ex_valid, ex_mem_read, ex_mdu_start;
    logic       mem_reg_write, mem_branch_taken, wb_reg_write;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;

    logic        pc_write16, if_id_write16, id_ex_write16, id_ex_bubble16;
    logic        ex_mem_bubble16, flush_if_id16, flush_id_ex16, mdu_busy16;
    logic [1:0]  fwd_a16, fwd_b16;
    logic [15:0] stall_count16;

    logic        pc_write2, if_id_write2, id_ex_write2, id_ex_bubble2;
    logic        ex_mem_bubble2, flush_if_id2, flush_id_ex2, mdu_busy2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [1:0]  stall_count2;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.MDU_LATENCY(LAT), .STALL_CNT_W(16)) dut16 (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_mdu_start(ex_mdu_start),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_branch_taken(mem_branch_taken),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .pc_write(pc_write16), .if_id_write(if_id_write16), .id_ex_write(id_ex_write16),
        .id_ex_bubble(id_ex_bubble16), .ex_mem_bubble(ex_mem_bubble16),
        .flush_if_id(flush_if_id16), .flush_id_ex(flush_id_ex16), .mdu_busy(mdu_busy16),
        .fwd_a(fwd_a16), .fwd_b(fwd_b16), .stall_count(stall_count16)
    );

    ex_hazard_ctrl #(.MDU_LATENCY(LAT), .STALL_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_mdu_start(ex_mdu_start),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_branch_taken(mem_branch_taken),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .pc_write(pc_write2), .if_id_write(if_id_write2), .id_ex_write(id_ex_write2),
        .id_ex_bubble(id_ex_bubble2), .ex_mem_bubble(ex_mem_bubble2),
        .flush_if_id(flush_if_id2), .flush_id_ex(flush_id_ex2), .mdu_busy(mdu_busy2),
        .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_count(stall_count2)
    );

    // ------------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    typedef struct packed {
        logic       pc_write;
        logic       if_id_write;
        logic       id_ex_write;
        logic       id_ex_bubble;
        logic       ex_mem_bubble;
        logic       flush_if_id;
        logic       flush_id_ex;
        logic       mdu_busy;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
    } ctrl_t;

    ctrl_t dut16_ctrl, dut2_ctrl;
    assign dut16_ctrl = {pc_write16, if_id_write16, id_ex_write16, id_ex_bubble16,
                         ex_mem_bubble16, flush_if_id16, flush_id_ex16, mdu_busy16,
                         fwd_a16, fwd_b16};
    assign dut2_ctrl  = {pc_write2, if_id_write2, id_ex_write2, id_ex_bubble2,
                         ex_mem_bubble2, flush_if_id2, flush_id_ex2, mdu_busy2,
                         fwd_a2, fwd_b2};

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    // mdu_age: number of cycles the current MDU op has already spent in EX
    // (0 = no MDU op in progress). An op occupies EX for LAT cycles and only
    // the last of them is a non-stall cycle.
    int mdu_age = 0;
    int sc16    = 0;
    int sc2     = 0;

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic model_mdu_stall();
        if (mdu_age == 0) return ex_valid && ex_mdu_start;
        return mdu_age < LAT - 1;
    endfunction

    function automatic ctrl_t model_ctrl();
        ctrl_t e;
        e = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, default: '0};
        if (reset) return e;
        e.mdu_busy = (mdu_age != 0);
        e.fwd_a    = model_fwd(ex_rs);
        e.fwd_b    = model_fwd(ex_rt);
        if (mem_branch_taken) begin
            e.flush_if_id   = 1'b1;
            e.flush_id_ex   = 1'b1;
            e.ex_mem_bubble = 1'b1;
        end else if (model_mdu_stall()) begin
            e.pc_write      = 1'b0;
            e.if_id_write   = 1'b0;
            e.id_ex_write   = 1'b0;
            e.ex_mem_bubble = 1'b1;
        end else if (id_valid && ex_valid && ex_mem_read && ex_rd != 0 &&
                     (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt))) begin
            e.pc_write     = 1'b0;
            e.if_id_write  = 1'b0;
            e.id_ex_bubble = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        ctrl_t e;
        e = model_ctrl();
        if (reset) begin
            mdu_age <= 0;
            sc16    <= 0;
            sc2     <= 0;
        end else begin
            if (mem_branch_taken)       mdu_age <= 0;
            else if (model_mdu_stall()) mdu_age <= mdu_age + 1;
            else                        mdu_age <= 0;
            if (!e.pc_write) begin
                if (sc16 < 65535) sc16 <= sc16 + 1;
                if (sc2 < 3)      sc2  <= sc2 + 1;
            end
        end
    end

    // Compare process: outputs are checked mid-cycle, away from the edge.
    always @(negedge clk) begin
        check("ctrl16", dut16_ctrl, model_ctrl());
        check("ctrl2", dut2_ctrl, model_ctrl());
        check("stall16", stall_count16, sc16);
        check("stall2", stall_count2, sc2);
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_valid = 0; ex_rs = 0; ex_rt = 0; ex_mem_read = 0; ex_rd = 0; ex_mdu_start = 0;
        mem_reg_write = 0; mem_rd = 0; mem_branch_taken = 0;
        wb_reg_write = 0; wb_rd = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        repeat (2) step();
        @(negedge clk);
        check("rst_pc_write", pc_write16, 1);
        check("rst_stall", stall_count16, 0);
        check("rst_busy", mdu_busy16, 0);
        step();
        reset = 0;

        // Load-use on rs: one stall cycle, then the load has moved on.
        id_valid = 1; id_rs = 5; ex_valid = 1; ex_mem_read = 1; ex_rd = 5;
        @(negedge clk);
        check("lu_pc_write", pc_write16, 0);
        check("lu_if_id_write", if_id_write16, 0);
        check("lu_bubble", id_ex_bubble16, 1);
        check("lu_cnt_before", stall_count16, 0);
        step();
        ex_mem_read = 0; ex_rd = 0;
        @(negedge clk);
        check("lu_next_pc_write", pc_write16, 1);
        check("lu_cnt_after", stall_count16, 1);

        // Load-use on rt only counts when the ID instruction reads rt.
        step();
        ex_mem_read = 1; ex_rd = 6; id_rs = 1; id_rt = 6; id_uses_rt = 1;
        @(negedge clk);
        check("lu_rt_pc_write", pc_write16, 0);
        step();
        id_uses_rt = 0;
        @(negedge clk);
        check("lu_rt_unused", pc_write16, 1);
        step();
        ex_rd = 0; id_rs = 0;
        @(negedge clk);
        check("lu_r0", pc_write16, 1);
        step();
        idle();

        // Forwarding priority and r0 exclusion.
        ex_rs = 7; mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1;
        @(negedge clk);
        check("fwd_exmem", fwd_a16, 2'b10);
        step();
        mem_reg_write = 0;
        @(negedge clk);
        check("fwd_memwb", fwd_a16, 2'b01);
        step();
        ex_rs = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1;
        @(negedge clk);
        check("fwd_r0", fwd_a16, 2'b00);
        step();
        ex_rt = 9; mem_rd = 3; wb_rd = 9; wb_reg_write = 1;
        @(negedge clk);
        check("fwd_b_memwb", fwd_b16, 2'b01);
        check("fwd_a_none", fwd_a16, 2'b00);
        step();
        idle();

        // MDU op held in EX: 3 stall cycles, busy for 3, then release.
        ex_valid = 1; ex_mdu_start = 1;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("mdu_pc_write", pc_write16, (i == LAT - 1));
            check("mdu_busy", mdu_busy16, (i != 0));
            check("mdu_bubble", ex_mem_bubble16, (i != LAT - 1));
            step();
        end
        idle();
        @(negedge clk);
        check("mdu_done_busy", mdu_busy16, 0);
        check("mdu_stall_cnt", stall_count16, 5);

        // Branch in the same cycle as an MDU start: branch wins.
        step();
        ex_valid = 1; ex_mdu_start = 1; mem_branch_taken = 1;
        @(negedge clk);
        check("br_flush_if_id", flush_if_id16, 1);
        check("br_flush_id_ex", flush_id_ex16, 1);
        check("br_ex_mem_bubble", ex_mem_bubble16, 1);
        check("br_pc_write", pc_write16, 1);
        check("br_busy", mdu_busy16, 0);
        step();
        idle();
        @(negedge clk);
        check("br_no_mdu", mdu_busy16, 0);
        check("br_stall_cnt", stall_count16, 5);

        // Branch aborting an MDU op already in progress.
        step();
        ex_valid = 1; ex_mdu_start = 1;
        step();
        mem_branch_taken = 1;
        @(negedge clk);
        check("abort_pc_write", pc_write16, 1);
        check("abort_busy_now", mdu_busy16, 1);
        step();
        idle();
        @(negedge clk);
        check("abort_busy_after", mdu_busy16, 0);
        check("abort_stall_cnt", stall_count16, 6);

        // Reset while busy with one stall cycle still to go.
        step();
        ex_valid = 1; ex_mdu_start = 1;
        step();
        step();
        reset = 1;
        @(negedge clk);
        check("rst_busy_pc_write", pc_write16, 1);
        check("rst_busy_out", mdu_busy16, 0);
        step();
        reset = 0;
        idle();
        @(negedge clk);
        check("post_rst_busy", mdu_busy16, 0);
        check("post_rst_stall", stall_count16, 0);
        check("post_rst_pc_write", pc_write16, 1);
        check("post_rst_id_ex_write", id_ex_write16, 1);

        // Five consecutive load-use stalls: the 2-bit counter saturates.
        step();
        id_valid = 1; id_rs = 5; ex_valid = 1; ex_mem_read = 1; ex_rd = 5;
        repeat (5) step();
        idle();
        @(negedge clk);
        check("sat_stall2", stall_count2, 3);
        check("sat_stall16", stall_count16, 5);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
